adder_checker: RTL and testbench

Self-checking hardware stimulus/response engine for the adder blocks. It drives every operand/carry-in combination into an external combinational adder under test and samples its `res`/`co` outputs a fixed number of cycles later. It compares each sample against an internal reference sum, then reports pass/fail, an error count and the first failing vector. It is the driving-and-checking end of the adder interface and is meant for on-chip self-test of `halfAdder`/full-adder instances.

---
 rtl/adder_checker.sv | 81 ++++++++
 tb/tb_adder_checker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/adder_checker.sv
// adder_checker: exhaustive stimulus/response checker for an external combinational adder
module adder_checker #(
  parameter int N   = 1,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [N-1:0]   op1,
  output logic [N-1:0]   op2,
  output logic           ci,
  input  logic [N-1:0]   res,
  input  logic           co,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [7:0]     err_count,
  output logic [2*N:0]   fail_vec
);
  localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] wcnt;
  logic          first_seen;
  logic [2*N:0]  v;
  logic [N:0]    ref_sum;
  logic          go, smp, last, mis;
  // The driven operands are the vector index itself, so no separate counter is kept
  assign v = {op1, op2, ci};
  // Sweep control strobes and the reference sum of the vector currently on the bus
  always_comb begin
    go      = start && state != RUN;
    smp     = state == RUN && wcnt == CW'(LAT - 1);
    last    = &v;
    ref_sum = (N+1)'(op1) + (N+1)'(op2) + (N+1)'(ci);
    mis     = {co, res} != ref_sum;
  end
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // Next state: start restarts from IDLE or DONE; the last sample finishes the sweep
  always_comb begin
    state_nx = go ? RUN : (smp && last) ? DONE : state;
  end
  // Status outputs decoded from state
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
    pass = done && err_count == 8'd0;
  end
  // Vector drive, latency wait, comparison and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {op1, op2, ci} <= '0;
      wcnt           <= '0;
      err_count      <= '0;
      fail_vec       <= '0;
      first_seen     <= 1'b0;
    end else if (go) begin
      {op1, op2, ci} <= '0;
      wcnt           <= '0;
      err_count      <= '0;
      fail_vec       <= '0;
      first_seen     <= 1'b0;
    end else if (state == RUN) begin
      if (smp) begin
        wcnt <= '0;
        if (mis) err_count <= err_count + {7'd0, ~&err_count};
        if (mis && !first_seen) begin
          fail_vec   <= v;
          first_seen <= 1'b1;
        end
        if (!last) {op1, op2, ci} <= v + 1'b1;
      end else begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_adder_checker.sv
// tb_adder_checker: directed sweeps of adder_checker against good, faulty and pipelined adder models
module tb_adder_checker;
  typedef struct {
    int id;
    int edge_n;
    int pass;
    int err;
    int fvec;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0;
  int   mode = 0;
  int   n_cmp = 0, n_mis = 0;
  exp_t q[$];
  bit   s1, s2, s3;
  always #5 clk = ~clk;
  // u0: N=1 LAT=1 combinational full adder, optional co stuck at 0
  logic [0:0] a0, b0, r0;
  logic       c0, co0, bz0, dn0, ps0;
  logic [7:0] ec0;
  logic [2:0] fv0;
  logic [1:0] s0;
  assign s0  = {1'b0, a0} + {1'b0, b0} + {1'b0, c0};
  assign r0  = s0[0];
  assign co0 = mode == 1 ? 1'b0 : s0[1];
  adder_checker #(.N(1), .LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .op1(a0), .op2(b0), .ci(c0),
    .res(r0), .co(co0), .busy(bz0), .done(dn0), .pass(ps0), .err_count(ec0), .fail_vec(fv0));
  // u1 / u2: N=2 adder with a 2-cycle registered output, checked at LAT=3 and LAT=1
  logic [1:0] a1, b1, a2, b2;
  logic       c1, c2, bz1, dn1, ps1, bz2, dn2, ps2;
  logic [2:0] p1a, p1b, p2a, p2b;
  logic [7:0] ec1, ec2;
  logic [4:0] fv1, fv2;
  always_ff @(posedge clk) begin
    p1a <= {1'b0, a1} + {1'b0, b1} + {2'b0, c1};
    p1b <= p1a;
    p2a <= {1'b0, a2} + {1'b0, b2} + {2'b0, c2};
    p2b <= p2a;
  end
  adder_checker #(.N(2), .LAT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op1(a1), .op2(b1), .ci(c1),
    .res(p1b[1:0]), .co(p1b[2]), .busy(bz1), .done(dn1), .pass(ps1), .err_count(ec1), .fail_vec(fv1));
  adder_checker #(.N(2), .LAT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op1(a2), .op2(b2), .ci(c2),
    .res(p2b[1:0]), .co(p2b[2]), .busy(bz2), .done(dn2), .pass(ps2), .err_count(ec2), .fail_vec(fv2));
  // u3: N=4 adder with inverted sum, every vector fails
  logic [3:0] a3, b3, r3;
  logic [4:0] s3v;
  logic       c3, co3, bz3, dn3, ps3;
  logic [7:0] ec3;
  logic [8:0] fv3;
  assign s3v = {1'b0, a3} + {1'b0, b3} + {4'b0, c3};
  assign r3  = ~s3v[3:0];
  assign co3 = s3v[4];
  adder_checker #(.N(4), .LAT(1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op1(a3), .op2(b3), .ci(c3),
    .res(r3), .co(co3), .busy(bz3), .done(dn3), .pass(ps3), .err_count(ec3), .fail_vec(fv3));

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_u0(input int m);
    exp_t e;
    int errs = 0, first = -1;
    for (int v = 0; v < 8; v++) begin
      int a = (v >> 2) & 1, b = (v >> 1) & 1, c = v & 1;
      int s = a + b + c;
      int o = m == 1 ? (s & 1) : s;
      if (o != s) begin
        errs++;
        if (first < 0) first = v;
      end
    end
    e.id = 0; e.edge_n = 8; e.pass = int'(errs == 0); e.err = errs; e.fvec = first < 0 ? 0 : first;
    q.push_back(e);
  endtask

  task automatic push(input int id, input int edge_n, input int ps, input int err, input int fvec);
    exp_t e;
    e.id = id; e.edge_n = edge_n; e.pass = ps; e.err = err; e.fvec = fvec;
    q.push_back(e);
  endtask

  task automatic pop_chk(input int id, input int k, input int ps, input int ec, input int fv);
    exp_t e;
    chk("sb_nonempty", int'(q.size() > 0), 1);
    if (q.size() == 0) return;
    e = q.pop_front();
    chk("sb_id", id, e.id);
    chk($sformatf("done_edge[%0d]", id), k, e.edge_n);
    chk($sformatf("pass[%0d]", id), ps, e.pass);
    if (e.err >= 0) chk($sformatf("err_count[%0d]", id), ec, e.err);
    if (e.fvec >= 0) chk($sformatf("fail_vec[%0d]", id), fv, e.fvec);
  endtask

  task automatic sweep0(input int m, input int repulse);
    int got = -1;
    mode = m;
    push_u0(m);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("e0_busy", int'(bz0), 1);
    chk("e0_done", int'(dn0), 0);
    chk("e0_vec", int'({a0, b0, c0}), 0);
    chk("e0_err", int'(ec0), 0);
    chk("e0_fvec", int'(fv0), 0);
    for (int k = 1; k <= 16; k++) begin
      start = k == repulse;
      tick();
      start = 1'b0;
      if (dn0) begin
        got = k;
        break;
      end
      chk("run_vec", int'({a0, b0, c0}), k);
      chk("run_busy", int'(bz0), 1);
    end
    chk("done_seen", int'(got >= 0), 1);
    pop_chk(0, got, int'(ps0), int'(ec0), int'(fv0));
    chk("end_busy", int'(bz0), 0);
    chk("end_vec", int'({a0, b0, c0}), 7);
  endtask

  initial begin
    #12;
    chk("rst_vec", int'({a0, b0, c0}), 0);
    chk("rst_busy", int'(bz0), 0);
    chk("rst_done", int'(dn0), 0);
    chk("rst_pass", int'(ps0), 0);
    chk("rst_err", int'(ec0), 0);
    chk("rst_fvec", int'(fv0), 0);
    rst_n = 1'b1;
    tick();
    sweep0(0, 0);
    sweep0(1, 0);
    sweep0(0, 4);
    mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("pre_rst_err", int'(ec0), 1);
    chk("pre_rst_fvec", int'(fv0), 3);
    chk("pre_rst_vec", int'({a0, b0, c0}), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vec", int'({a0, b0, c0}), 0);
    chk("arst_busy", int'(bz0), 0);
    chk("arst_err", int'(ec0), 0);
    chk("arst_fvec", int'(fv0), 0);
    chk("arst_done", int'(dn0), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_busy", int'(bz0), 0);
    sweep0(0, 0);
    push(2, 32, 0, -1, -1);
    push(1, 96, 1, 0, 0);
    push(3, 512, 0, 255, 0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("u1_e0_busy", int'(bz1), 1);
    for (int k = 1; k <= 600; k++) begin
      tick();
      if (!s1 && k < 96) chk("u1_vec", int'({a1, b1, c1}), k / 3);
      if (dn2 && !s2) begin
        s2 = 1'b1;
        pop_chk(2, k, int'(ps2), int'(ec2), int'(fv2));
      end
      if (dn1 && !s1) begin
        s1 = 1'b1;
        pop_chk(1, k, int'(ps1), int'(ec1), int'(fv1));
      end
      if (dn3 && !s3) begin
        s3 = 1'b1;
        pop_chk(3, k, int'(ps3), int'(ec3), int'(fv3));
      end
      if (s1 && s2 && s3) break;
    end
    chk("u1_done_seen", int'(s1), 1);
    chk("u2_done_seen", int'(s2), 1);
    chk("u3_done_seen", int'(s3), 1);
    chk("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
